// File: rtl/trace_dump_ctrl_pkg.sv
// rtl/trace_dump_ctrl_pkg.sv - shared state encoding and beat tag constants for the trace dump controller
package trace_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_EMIT,
        ST_HOLD,
        ST_STEP,
        ST_DONE
    } state_e;

    localparam int TAG_W = 6;
    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t TAG_PC   = 6'd0;
    localparam tag_t TAG_INST = 6'd1;
    localparam tag_t TAG_REG0 = 6'd2;

endpackage

// File: rtl/trace_dump_ctrl_out_stage.sv
// rtl/trace_dump_ctrl_out_stage.sv - single-entry valid/ready register holding one trace beat
module trace_dump_ctrl_out_stage
    import trace_dump_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  tag_t              in_tag_i,
    input  logic              in_last_i,
    output logic              load_en_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output tag_t              out_tag_o,
    output logic              out_last_o
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    tag_t              tag_q;
    logic              last_q;

    // Refill is allowed whenever the slot is empty or its beat leaves this cycle.
    assign load_en_o = !valid_q || out_ready_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
            last_q  <= 1'b0;
        end else if (load_en_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
                tag_q  <= in_tag_i;
                last_q <= in_last_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_tag_o   = tag_q;
    assign out_last_o  = last_q;

endmodule

// File: rtl/trace_dump_ctrl.sv
// rtl/trace_dump_ctrl.sv - freezes the CPU, streams pc/inst/regfile per retired instruction, then steps once
module trace_dump_ctrl
    import trace_dump_ctrl_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int MAX_STEPS = 4000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [31:0]      cpu_pc,
    input  logic [31:0]      cpu_inst,
    output logic             cpu_stall,
    output logic [4:0]       dbg_raddr,
    input  logic [31:0]      dbg_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output tag_t             out_tag,
    output logic             out_last,
    output logic [CNT_W-1:0] step_count,
    output logic             done
);

    localparam int               BEATS     = NREG + 2;
    localparam tag_t             TAG_LAST  = tag_t'(BEATS - 1);
    localparam logic [CNT_W-1:0] STEPS_MAX = CNT_W'(MAX_STEPS);

    state_e           state_q;
    logic [31:0]      inst_q;
    logic [4:0]       raddr_q;
    logic [CNT_W-1:0] count_q;
    logic             done_q;

    logic             load_en;
    logic             accept;
    logic             push_d;
    tag_t             tag_d;
    logic [31:0]      data_d;
    logic             last_d;

    assign accept = out_valid && out_ready;

    // Next beat to load: pc at capture, otherwise the tag after the one on the port.
    always_comb begin
        push_d = 1'b0;
        tag_d  = out_tag + tag_t'(1);
        data_d = dbg_rdata;
        if (state_q == ST_CAPTURE) begin
            push_d = load_en;
            tag_d  = TAG_PC;
            data_d = cpu_pc;
        end else if (state_q == ST_EMIT) begin
            push_d = accept && !out_last;
        end
        if (tag_d == TAG_INST) begin
            data_d = inst_q;
        end
        last_d = (tag_d == TAG_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            inst_q  <= '0;
            raddr_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        if (MAX_STEPS == 0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (load_en) begin
                        inst_q  <= cpu_inst;
                        raddr_q <= '0;
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (accept) begin
                        if (out_last) begin
                            count_q <= count_q + CNT_W'(1);
                            if (count_q + CNT_W'(1) == STEPS_MAX) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else if (enable) begin
                                state_q <= ST_STEP;
                            end else begin
                                state_q <= ST_HOLD;
                            end
                        end else if (tag_d >= TAG_REG0) begin
                            // dbg_rdata for reg i is consumed now, so address reg i+1 for next beat.
                            raddr_q <= raddr_q + 5'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (enable) begin
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_CAPTURE;
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    trace_dump_ctrl_out_stage #(
        .DATA_W (32)
    ) u_out_stage (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid_i  (push_d),
        .in_data_i   (data_d),
        .in_tag_i    (tag_d),
        .in_last_i   (last_d),
        .load_en_o   (load_en),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_tag_o   (out_tag),
        .out_last_o  (out_last)
    );

    assign cpu_stall  = (state_q != ST_STEP);
    assign dbg_raddr  = raddr_q;
    assign step_count = count_q;
    assign done       = done_q;

endmodule

// File: tb/tb_trace_dump_ctrl.sv
// tb/tb_trace_dump_ctrl.sv - bench for trace_dump_ctrl with a beat-level reference model and directed scenarios
module tb_trace_dump_ctrl;

    localparam int NREG = 32;
    localparam int MAXS = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        en0;
    logic [31:0] pc;
    logic [31:0] regs [32];
    logic        preload_req;
    int          rmode;

    logic        cpu_stall, out_valid, out_ready, out_last, done;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata, out_data, cpu_inst;
    logic [5:0]  out_tag;
    logic [15:0] step_count;

    logic        cpu_stall0, out_valid0, out_last0, done0;
    logic [4:0]  dbg_raddr0;
    logic [31:0] dbg_rdata0, out_data0;
    logic [5:0]  out_tag0;
    logic [15:0] step_count0;

    int total = 0;
    int bad = 0;

    int cyc = 0, m_tag = 0, m_rec = 0, m_step_at = -1, n_step = 0, step_cyc = -1;
    int t0_cyc = 0, t33_cyc = 0, n_acc = 0, n_acc_rec = 0, n_stall = 0, n_stall_rec = 0;
    bit m_hold = 0, p_stuck = 0;
    logic [31:0] p_data, exp_data;
    logic [5:0]  p_tag;
    logic        p_last;
    logic [31:0] rec_data [34];

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] p);
        return {p[15:0], ~p[31:16]} ^ 32'h0000_0013;
    endfunction

    assign cpu_inst   = inst_of(pc);
    assign dbg_rdata  = regs[dbg_raddr];
    assign dbg_rdata0 = regs[dbg_raddr0];

    trace_dump_ctrl #(.NREG(NREG), .MAX_STEPS(MAXS), .CNT_W(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .cpu_pc(pc), .cpu_inst(cpu_inst),
        .cpu_stall(cpu_stall), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_last(out_last), .step_count(step_count), .done(done)
    );

    trace_dump_ctrl #(.NREG(NREG), .MAX_STEPS(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .enable(en0), .cpu_pc(pc), .cpu_inst(cpu_inst),
        .cpu_stall(cpu_stall0), .dbg_raddr(dbg_raddr0), .dbg_rdata(dbg_rdata0),
        .out_valid(out_valid0), .out_ready(1'b1), .out_data(out_data0), .out_tag(out_tag0),
        .out_last(out_last0), .step_count(step_count0), .done(done0)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Beat-level reference: expected stream, handshake stability and step timing.
    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            if (preload_req) begin
                for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h0101_0101;
                pc = 32'h0040_0000;
            end
            check("dut0_stall", cpu_stall0, 1);
            check("dut0_valid", out_valid0, 0);
            check("dut0_tag", out_tag0, 0);
            check("dut0_data", out_data0, 0);
            check("dut0_last", out_last0, 0);
            check("dut0_count", step_count0, 0);
            if (!reset_n) begin
                check("rst_valid", out_valid, 0);
                check("rst_count", step_count, 0);
                check("rst_stall", cpu_stall, 1);
                m_tag = 0; m_rec = 0; m_step_at = -1; m_hold = 0; p_stuck = 0;
                n_step = 0; n_acc = 0; n_stall = 0;
            end else begin
                check("step_count", step_count, m_rec);
                check("done", done, m_rec == MAXS);
                check("stall", cpu_stall, cyc != m_step_at);
                if (m_rec == MAXS) check("valid_after_done", out_valid, 0);
                if (m_step_at >= 0 && cyc == m_step_at + 2)
                    check("restart_beat", out_valid && out_tag == 6'd0, 1);
                if (p_stuck) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, p_data);
                    check("hold_tag", out_tag, p_tag);
                    check("hold_last", out_last, p_last);
                    n_stall++;
                end
                if (!cpu_stall) begin
                    n_step++;
                    step_cyc = cyc;
                end
                if (m_hold && enable) begin
                    m_step_at = cyc + 1;
                    m_hold = 0;
                end
                if (out_valid && out_ready) begin
                    exp_data = (m_tag == 0) ? pc : (m_tag == 1) ? inst_of(pc) : regs[m_tag-2];
                    check("beat_tag", out_tag, m_tag);
                    check("beat_data", out_data, exp_data);
                    check("beat_last", out_last, m_tag == NREG + 1);
                    rec_data[m_tag] = out_data;
                    n_acc++;
                    if (m_tag == 0) t0_cyc = cyc;
                    if (m_tag == NREG + 1) begin
                        m_rec++;
                        m_tag = 0;
                        t33_cyc = cyc;
                        n_acc_rec = n_acc; n_acc = 0;
                        n_stall_rec = n_stall; n_stall = 0;
                        if (m_rec != MAXS) begin
                            if (enable) m_step_at = cyc + 1;
                            else m_hold = 1;
                        end
                    end else begin
                        m_tag++;
                    end
                end
                p_stuck = out_valid && !out_ready;
                p_data = out_data;
                p_tag = out_tag;
                p_last = out_last;
                if (!cpu_stall) begin
                    pc = pc + 32'd4;
                    regs[$urandom_range(31, 1)] = $urandom;
                end
            end
        end
    end

    initial begin : ready_drv
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = !out_ready;
                default: out_ready = ($urandom % 3) != 0;
            endcase
        end
    end

    task automatic wait_rec(input int n, input string nm);
        int k = 0;
        while (m_rec < n && k < 3000) begin
            @(posedge clk); #1; k++;
        end
        check(nm, m_rec >= n, 1);
    endtask

    task automatic wait_tag(input int t, input string nm);
        int k = 0;
        while (!(out_valid && out_tag == 6'(t)) && k < 3000) begin
            @(posedge clk); #1; k++;
        end
        check(nm, out_valid && out_tag == 6'(t), 1);
    endtask

    initial begin : stim
        int t33a, t33b, ns, k;
        reset_n = 1'b0; enable = 1'b0; en0 = 1'b0; rmode = 0; preload_req = 1'b1;
        pc = 32'h0040_0000;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_data", out_data, 0);
        check("reset_tag", out_tag, 0);
        check("reset_last", out_last, 0);
        check("reset_raddr", dbg_raddr, 0);
        check("reset_count", step_count, 0);
        check("reset_done", done, 0);
        check("reset_stall", cpu_stall, 1);
        preload_req = 1'b0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: ready high, back-to-back beats
        enable = 1'b1;
        @(posedge clk); #1;
        check("t1_capture_idle_port", out_valid, 0);
        @(posedge clk); #1;
        check("t1_first_beat", out_valid && out_tag == 6'd0, 1);
        wait_rec(1, "t1_timeout");
        t33a = t33_cyc;
        check("t1_pc", rec_data[0], 32'h0040_0000);
        check("t1_reg5", rec_data[7], 32'h0505_0505);
        check("t1_count", step_count, 1);
        check("t1_consecutive", t33_cyc - t0_cyc, 33);
        rmode = 1;
        repeat (2) @(posedge clk);
        #1;
        check("t1_step_after_last", step_cyc - t33a, 1);

        // 2: alternating ready
        wait_rec(2, "t2_timeout");
        t33b = t33_cyc;
        rmode = 0;
        check("t2_beats", n_acc_rec, 34);
        check("t2_stalled", n_stall_rec >= 33, 1);

        // 3: run into DONE at MAX_STEPS
        wait_rec(3, "t3_timeout");
        repeat (10) @(posedge clk);
        #1;
        check("t3_done", done, 1);
        check("t3_count", step_count, 3);
        check("t3_steps", n_step, 2);
        check("t3_no_valid", out_valid, 0);
        check("t3_gap", t0_cyc - t33b, 3);
        check("t3_consecutive", t33_cyc - t0_cyc, 33);

        // 4: enable dropped mid-record, HOLD, then one step
        reset_n = 1'b0; enable = 1'b0; preload_req = 1'b1; rmode = 2;
        repeat (2) @(posedge clk);
        #1;
        preload_req = 1'b0;
        reset_n = 1'b1;
        enable = 1'b1;
        wait_tag(10, "t4_tag10");
        enable = 1'b0;
        wait_rec(1, "t4_timeout");
        ns = n_step;
        repeat (20) @(posedge clk);
        #1;
        check("t4_hold_no_step", n_step, ns);
        check("t4_hold_stall", cpu_stall, 1);
        check("t4_hold_port", out_valid, 0);
        enable = 1'b1;
        wait_tag(20, "t4_tag20");
        check("t4_one_step", n_step, ns + 1);
        check("t4_new_pc", rec_data[0], 32'h0040_0004);

        // 5: asynchronous reset with tag 20 pending
        reset_n = 1'b0;
        #1;
        check("t5_async_drop", out_valid, 0);
        check("t5_count", step_count, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1; k++;
        end
        check("t5_restart_valid", out_valid, 1);
        check("t5_restart_tag", out_tag, 0);
        enable = 1'b0;
        wait_rec(1, "t5_timeout");
        repeat (5) @(posedge clk);
        #1;

        // 6: MAX_STEPS = 0
        en0 = 1'b1;
        check("t6_not_yet", done0, 0);
        @(posedge clk); #1;
        check("t6_done", done0, 1);
        repeat (5) @(posedge clk);
        #1;
        check("t6_sticky", done0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
